// File: rtl/dbg_trace_fifo.sv
// Instruction-trace capture FIFO fed by the CPU debug bus.
// Logs one {pc, inst, seq} entry per entry into CAPT_STATE.
module dbg_trace_fifo #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [3:0] CAPT_STATE = 4'd1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            dbg_state,
    input  logic [31:0]           dbg_pc,
    input  logic [31:0]           dbg_inst,
    input  logic                  trace_en,
    input  logic                  clr,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [31:0]           rd_pc,
    output logic [31:0]           rd_inst,
    output logic [15:0]           rd_seq,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    localparam ptr_t PTR_ONE = 1;

    logic [79:0]         mem [DEPTH];
    ptr_t                wr_ptr;
    ptr_t                rd_ptr;
    ptr_t                rd_ptr_nxt;
    logic [15:0]         seq;
    logic                in_capt;
    logic                capt_evt;
    logic                full;
    logic                pop;
    logic                push;
    logic [DEPTH_LOG2:0] count_nxt;
    logic [79:0]         wr_data;
    logic [79:0]         head_nxt;

    assign capt_evt   = trace_en && (dbg_state == CAPT_STATE) && !in_capt;
    assign full       = (count == FULL_CNT);
    assign rd_valid   = (count != '0);
    assign pop        = rd_valid && rd_ready;
    assign push       = capt_evt && (!full || pop);
    assign wr_data    = {dbg_pc, dbg_inst, seq};
    assign rd_ptr_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // The new head is the entry being written when nothing else remains.
    always_comb begin
        head_nxt = mem[rd_ptr_nxt];
        if (push && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            seq      <= '0;
            in_capt  <= 1'b0;
            rd_pc    <= '0;
            rd_inst  <= '0;
            rd_seq   <= '0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            seq      <= '0;
            in_capt  <= 1'b0;
        end else begin
            in_capt <= (dbg_state == CAPT_STATE);
            if (capt_evt) begin
                seq <= seq + 16'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (capt_evt && full && !pop) begin
                overflow <= 1'b1;
            end
            if (count_nxt != '0) begin
                {rd_pc, rd_inst, rd_seq} <= head_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dbg_trace_fifo.sv
// Randomized bench for dbg_trace_fifo against a queue-based model.
module tb_dbg_trace_fifo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  dbg_state = '0;
    logic [31:0] dbg_pc = '0;
    logic [31:0] dbg_inst = '0;
    logic        trace_en = 1'b0;
    logic        clr = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [15:0] rd_seq;
    logic [4:0]  count;
    logic        overflow;

    always #5 clk = ~clk;

    dbg_trace_fifo dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dbg_state (dbg_state),
        .dbg_pc    (dbg_pc),
        .dbg_inst  (dbg_inst),
        .trace_en  (trace_en),
        .clr       (clr),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_pc     (rd_pc),
        .rd_inst   (rd_inst),
        .rd_seq    (rd_seq),
        .count     (count),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [15:0] seq;
    } ent_t;

    ent_t        q[$];
    ent_t        m_head;
    logic [15:0] m_seq;
    logic        m_in;
    logic        m_ovf;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void model_reset();
        q.delete();
        m_head = '0;
        m_seq  = '0;
        m_in   = 1'b0;
        m_ovf  = 1'b0;
    endfunction

    // One rising edge: pop before push, so full+pop+event keeps both.
    function automatic void model_edge();
        bit evt;
        ent_t e;
        evt = trace_en && (dbg_state == 4'd1) && !m_in;
        if (clr) begin
            q.delete();
            m_seq = '0;
            m_in  = 1'b0;
            m_ovf = 1'b0;
            return;
        end
        if (q.size() > 0 && rd_ready) void'(q.pop_front());
        if (evt) begin
            e.pc = dbg_pc;
            e.inst = dbg_inst;
            e.seq = m_seq;
            if (q.size() < 16) q.push_back(e);
            else m_ovf = 1'b1;
            m_seq = m_seq + 16'd1;
        end
        m_in = (dbg_state == 4'd1);
        if (q.size() > 0) m_head = q[0];
    endfunction

    task automatic compare_all();
        check_eq("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        check_eq("count", 32'(count), 32'(q.size()));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("rd_pc", rd_pc, m_head.pc);
        check_eq("rd_inst", rd_inst, m_head.inst);
        check_eq("rd_seq", 32'(rd_seq), 32'(m_head.seq));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
        compare_all();
    endtask

    task automatic drive(input logic [3:0] st, input logic rdy);
        dbg_state = st;
        dbg_pc    = $urandom;
        dbg_inst  = $urandom;
        rd_ready  = rdy;
    endtask

    task automatic do_clr();
        drive(4'd0, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic events(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            drive(4'd1, rdy);
            step();
            drive(4'd0, rdy);
            step();
        end
    endtask

    initial begin
        logic [15:0] exp_next;
        int          got_n;

        model_reset();
        #12;
        compare_all();
        reset_n  = 1'b1;
        trace_en = 1'b1;

        // Single capture
        dbg_state = 4'd0;
        dbg_pc    = 32'h0040_0000;
        dbg_inst  = 32'h8C08_0004;
        step();
        dbg_state = 4'd1;
        step();
        check_eq("single_valid", 32'(rd_valid), 32'd1);
        check_eq("single_pc", rd_pc, 32'h0040_0000);
        check_eq("single_inst", rd_inst, 32'h8C08_0004);
        check_eq("single_seq", 32'(rd_seq), 32'd0);
        check_eq("single_count", 32'(count), 32'd1);
        dbg_state = 4'd2;
        step();

        // Stall in capture state
        do_clr();
        for (int i = 0; i < 5; i++) begin
            drive(4'd1, 1'b0);
            step();
        end
        check_eq("stall_count", 32'(count), 32'd1);
        drive(4'd2, 1'b0);
        step();
        drive(4'd1, 1'b0);
        step();
        check_eq("reenter_count", 32'(count), 32'd2);
        drive(4'd0, 1'b1);
        step();
        check_eq("reenter_seq", 32'(rd_seq), 32'd1);

        // Overflow, drain, and the seq gap after drops
        do_clr();
        events(18, 1'b0);
        check_eq("ovf_count", 32'(count), 32'd16);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check_eq("drain_seq", 32'(rd_seq), 32'(i));
            drive(4'd0, 1'b1);
            step();
        end
        check_eq("drain_empty", 32'(rd_valid), 32'd0);
        drive(4'd1, 1'b0);
        step();
        check_eq("post_ovf_seq", 32'(rd_seq), 32'd18);

        // Full with simultaneous event and pop
        do_clr();
        events(16, 1'b0);
        check_eq("full_count", 32'(count), 32'd16);
        drive(4'd1, 1'b1);
        step();
        check_eq("fullpop_count", 32'(count), 32'd16);
        check_eq("fullpop_ovf", 32'(overflow), 32'd0);
        check_eq("fullpop_head", 32'(rd_seq), 32'd1);

        // Wrap with rd_ready toggling every cycle
        do_clr();
        exp_next = '0;
        got_n = 0;
        for (int i = 0; i < 120; i++) begin
            drive((i % 3 == 2) ? 4'd0 : 4'd1, 1'(i % 2));
            if (rd_valid && rd_ready) begin
                check_eq("wrap_order", 32'(rd_seq), 32'(exp_next));
                exp_next = exp_next + 16'd1;
                got_n++;
            end
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(4'd0, 1'b1);
            if (rd_valid) begin
                check_eq("wrap_order", 32'(rd_seq), 32'(exp_next));
                exp_next = exp_next + 16'd1;
                got_n++;
            end
            step();
        end
        check_eq("wrap_total", 32'(got_n), 32'd40);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(4'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
            trace_en = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 99) == 0);
            step();
            clr = 1'b0;
        end
        trace_en = 1'b1;

        // clr together with an event
        do_clr();
        events(17, 1'b0);
        drive(4'd1, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("clr_count", 32'(count), 32'd0);
        check_eq("clr_ovf", 32'(overflow), 32'd0);
        check_eq("clr_valid", 32'(rd_valid), 32'd0);
        drive(4'd0, 1'b0);
        step();
        drive(4'd1, 1'b0);
        step();
        check_eq("clr_next_seq", 32'(rd_seq), 32'd0);

        // Asynchronous reset mid-stream
        do_clr();
        events(5, 1'b0);
        check_eq("pre_rst_count", 32'(count), 32'd5);
        @(posedge clk);
        model_edge();
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_pc", rd_pc, 32'd0);
        check_eq("rst_inst", rd_inst, 32'd0);
        check_eq("rst_seq", 32'(rd_seq), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        #10;
        reset_n = 1'b1;
        events(3, 1'b0);
        check_eq("post_rst_count", 32'(count), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
